// File: rtl/e203_exu_longp_wbck_sched.sv
// e203_exu_longp_wbck_sched: buffers LSU/NICE long-pipe results by itag and retires them in OITF order
// to the register file or to the exception port.
module e203_exu_longp_wbck_sched #(
    parameter int OITF_DEPTH = 2,
    parameter int ITAG_W     = 1,
    parameter int XLEN       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_wbck_i_valid,
    output logic              lsu_wbck_i_ready,
    input  logic [XLEN-1:0]   lsu_wbck_i_wdat,
    input  logic [ITAG_W-1:0] lsu_wbck_i_itag,
    input  logic              lsu_wbck_i_err,
    input  logic              nice_wbck_i_valid,
    output logic              nice_wbck_i_ready,
    input  logic [XLEN-1:0]   nice_wbck_i_wdat,
    input  logic [ITAG_W-1:0] nice_wbck_i_itag,
    input  logic              nice_wbck_i_err,
    input  logic              oitf_empty,
    input  logic [ITAG_W-1:0] oitf_ret_ptr,
    input  logic [4:0]        oitf_ret_rdidx,
    input  logic              oitf_ret_rdwen,
    input  logic [XLEN-1:0]   oitf_ret_pc,
    output logic              oitf_ret_ena,
    output logic              rf_wbck_o_valid,
    input  logic              rf_wbck_o_ready,
    output logic [XLEN-1:0]   rf_wbck_o_wdat,
    output logic [4:0]        rf_wbck_o_rdidx,
    output logic              excp_o_valid,
    input  logic              excp_o_ready,
    output logic [XLEN-1:0]   excp_o_pc,
    output logic [ITAG_W:0]   buf_occ
);
    localparam int OW = ITAG_W + 1;

    logic [OITF_DEPTH-1:0] slot_vld;
    logic [OITF_DEPTH-1:0] slot_err;
    logic [XLEN-1:0]       slot_wdat [OITF_DEPTH];
    logic lsu_acc, nice_acc, cand, cand_err;

    // A NICE write colliding with a same-tag LSU write yields to the LSU.
    assign lsu_wbck_i_ready  = ~slot_vld[lsu_wbck_i_itag];
    assign nice_wbck_i_ready = ~slot_vld[nice_wbck_i_itag]
                             & ~(lsu_wbck_i_valid & (lsu_wbck_i_itag == nice_wbck_i_itag));
    assign lsu_acc  = lsu_wbck_i_valid & lsu_wbck_i_ready;
    assign nice_acc = nice_wbck_i_valid & nice_wbck_i_ready;

    assign cand            = ~oitf_empty & slot_vld[oitf_ret_ptr];
    assign cand_err        = slot_err[oitf_ret_ptr];
    assign excp_o_valid    = cand & cand_err;
    assign excp_o_pc       = oitf_ret_pc;
    assign rf_wbck_o_valid = cand & ~cand_err & oitf_ret_rdwen;
    assign rf_wbck_o_wdat  = slot_wdat[oitf_ret_ptr];
    assign rf_wbck_o_rdidx = oitf_ret_rdidx;
    assign oitf_ret_ena    = cand & (cand_err ? excp_o_ready : (~oitf_ret_rdwen | rf_wbck_o_ready));

    // Retire and accept never target the same slot: accept needs it empty, retire needs it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_vld <= '0;
            buf_occ  <= '0;
        end else begin
            for (int i = 0; i < OITF_DEPTH; i++) begin
                if (oitf_ret_ena && oitf_ret_ptr == ITAG_W'(i)) slot_vld[i] <= 1'b0;
                if (lsu_acc && lsu_wbck_i_itag == ITAG_W'(i)) slot_vld[i] <= 1'b1;
                if (nice_acc && nice_wbck_i_itag == ITAG_W'(i)) slot_vld[i] <= 1'b1;
            end
            buf_occ <= buf_occ + OW'(lsu_acc) + OW'(nice_acc) - OW'(oitf_ret_ena);
        end
    end

    always_ff @(posedge clk) begin
        if (lsu_acc) begin
            slot_wdat[lsu_wbck_i_itag] <= lsu_wbck_i_wdat;
            slot_err[lsu_wbck_i_itag]  <= lsu_wbck_i_err;
        end
        if (nice_acc) begin
            slot_wdat[nice_wbck_i_itag] <= nice_wbck_i_wdat;
            slot_err[nice_wbck_i_itag]  <= nice_wbck_i_err;
        end
    end
endmodule

// File: tb/tb_e203_exu_longp_wbck_sched.sv
// tb_e203_exu_longp_wbck_sched: directed vectors with hand-computed expectations.
module tb_e203_exu_longp_wbck_sched;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid, lsu_ready, lsu_itag, lsu_err;
    logic [31:0] lsu_wdat;
    logic        nice_valid, nice_ready, nice_itag, nice_err;
    logic [31:0] nice_wdat;
    logic        oitf_empty, ret_ptr, rdwen, ret_ena;
    logic [4:0]  rdidx, rf_rdidx;
    logic [31:0] ret_pc, rf_wdat, excp_pc;
    logic        rf_valid, rf_ready, excp_valid, excp_ready;
    logic [1:0]  buf_occ;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    e203_exu_longp_wbck_sched dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_wbck_i_valid(lsu_valid), .lsu_wbck_i_ready(lsu_ready), .lsu_wbck_i_wdat(lsu_wdat),
        .lsu_wbck_i_itag(lsu_itag), .lsu_wbck_i_err(lsu_err),
        .nice_wbck_i_valid(nice_valid), .nice_wbck_i_ready(nice_ready), .nice_wbck_i_wdat(nice_wdat),
        .nice_wbck_i_itag(nice_itag), .nice_wbck_i_err(nice_err),
        .oitf_empty(oitf_empty), .oitf_ret_ptr(ret_ptr), .oitf_ret_rdidx(rdidx),
        .oitf_ret_rdwen(rdwen), .oitf_ret_pc(ret_pc), .oitf_ret_ena(ret_ena),
        .rf_wbck_o_valid(rf_valid), .rf_wbck_o_ready(rf_ready), .rf_wbck_o_wdat(rf_wdat),
        .rf_wbck_o_rdidx(rf_rdidx), .excp_o_valid(excp_valid), .excp_o_ready(excp_ready),
        .excp_o_pc(excp_pc), .buf_occ(buf_occ)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        lsu_valid = 0; lsu_itag = 0; lsu_err = 0; lsu_wdat = '0;
        nice_valid = 0; nice_itag = 0; nice_err = 0; nice_wdat = '0;
        oitf_empty = 1; ret_ptr = 0; rdwen = 1; rdidx = 5'd5; ret_pc = '0;
        rf_ready = 1; excp_ready = 0;
        #1;
        chk("rst_occ", 32'(buf_occ), 0);
        chk("rst_rfv", 32'(rf_valid), 0);
        chk("rst_exv", 32'(excp_valid), 0);
        chk("rst_ena", 32'(ret_ena), 0);
        chk("rst_lrdy", 32'(lsu_ready), 1);
        chk("rst_nrdy", 32'(nice_ready), 1);
        tick; rst_n = 1'b1;
        tick;

        // basic LSU result to register file
        oitf_empty = 0; lsu_valid = 1; lsu_itag = 0; lsu_wdat = 32'h12345678;
        #1;
        chk("t1_lrdy", 32'(lsu_ready), 1);
        chk("t1_nobyp", 32'(rf_valid), 0);
        chk("t1_noena", 32'(ret_ena), 0);
        tick; lsu_valid = 0; #1;
        chk("t1_occ1", 32'(buf_occ), 1);
        chk("t1_rfv", 32'(rf_valid), 1);
        chk("t1_wdat", rf_wdat, 32'h12345678);
        chk("t1_rdidx", 32'(rf_rdidx), 5);
        chk("t1_ena", 32'(ret_ena), 1);
        tick; #1;
        chk("t1_occ0", 32'(buf_occ), 0);
        chk("t1_ena0", 32'(ret_ena), 0);

        // out-of-order arrival: NICE itag1 first
        nice_valid = 1; nice_itag = 1; nice_wdat = 32'hAAAA0001; #1;
        chk("t2_noena_a", 32'(ret_ena), 0);
        tick; nice_valid = 0; #1;
        chk("t2_occ1", 32'(buf_occ), 1);
        chk("t2_noena_b", 32'(ret_ena), 0);
        chk("t2_norfv", 32'(rf_valid), 0);
        chk("t2_nrdy1", 32'(nice_ready), 0);
        tick; #1;
        chk("t2_noena_c", 32'(ret_ena), 0);
        lsu_valid = 1; lsu_itag = 0; lsu_wdat = 32'hBBBB0000;
        tick; lsu_valid = 0; #1;
        chk("t2_occ2", 32'(buf_occ), 2);
        chk("t2_ena0", 32'(ret_ena), 1);
        chk("t2_wd0", rf_wdat, 32'hBBBB0000);
        tick; ret_ptr = 1; #1;
        chk("t2_occ_a", 32'(buf_occ), 1);
        chk("t2_ena1", 32'(ret_ena), 1);
        chk("t2_wd1", rf_wdat, 32'hAAAA0001);
        tick; ret_ptr = 0; #1;
        chk("t2_occ_b", 32'(buf_occ), 0);
        chk("t2_wrap", 32'(ret_ena), 0);

        // same-itag collision, empty OITF gating, retire-slot write block
        oitf_empty = 1; ret_ptr = 1;
        lsu_valid = 1; lsu_itag = 1; lsu_wdat = 32'h11;
        nice_valid = 1; nice_itag = 1; nice_wdat = 32'h22; #1;
        chk("t3_lrdy", 32'(lsu_ready), 1);
        chk("t3_nrdy", 32'(nice_ready), 0);
        tick; lsu_valid = 0; nice_valid = 0; #1;
        chk("t3_occ", 32'(buf_occ), 1);
        chk("t3_empty_ena", 32'(ret_ena), 0);
        chk("t3_empty_rfv", 32'(rf_valid), 0);
        oitf_empty = 0; lsu_valid = 1; #1;
        chk("t3_ena", 32'(ret_ena), 1);
        chk("t3_wd", rf_wdat, 32'h11);
        chk("t3_blk", 32'(lsu_ready), 0);
        tick; lsu_valid = 0; ret_ptr = 0; #1;
        chk("t3_occ0", 32'(buf_occ), 0);

        // error result held until excp_o_ready
        ret_pc = 32'h80000100; excp_ready = 0;
        lsu_valid = 1; lsu_itag = 0; lsu_err = 1; lsu_wdat = 32'hDEAD;
        tick; lsu_valid = 0; lsu_err = 0; #1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_exv", 32'(excp_valid), 1);
            chk("t4_pc", excp_pc, 32'h80000100);
            chk("t4_rfv", 32'(rf_valid), 0);
            chk("t4_noena", 32'(ret_ena), 0);
            tick;
        end
        excp_ready = 1; #1;
        chk("t4_exv4", 32'(excp_valid), 1);
        chk("t4_pc4", excp_pc, 32'h80000100);
        chk("t4_rfv4", 32'(rf_valid), 0);
        chk("t4_ena4", 32'(ret_ena), 1);
        tick; excp_ready = 0; #1;
        chk("t4_exv0", 32'(excp_valid), 0);
        chk("t4_occ0", 32'(buf_occ), 0);

        // rdwen=0 retires without waiting for rf_ready
        rdwen = 0; rf_ready = 0;
        lsu_valid = 1; lsu_itag = 0; lsu_wdat = 32'h5;
        tick; lsu_valid = 0; #1;
        chk("t5_ena", 32'(ret_ena), 1);
        chk("t5_rfv", 32'(rf_valid), 0);
        chk("t5_exv", 32'(excp_valid), 0);
        tick; #1;
        chk("t5_occ0", 32'(buf_occ), 0);

        // full buffer stalled, then asynchronous reset
        rdwen = 1;
        lsu_valid = 1; lsu_itag = 0; lsu_wdat = 32'hC0;
        nice_valid = 1; nice_itag = 1; nice_wdat = 32'hC1; #1;
        chk("t6_lrdy", 32'(lsu_ready), 1);
        chk("t6_nrdy", 32'(nice_ready), 1);
        tick; lsu_valid = 0; nice_valid = 0; #1;
        chk("t6_occ2", 32'(buf_occ), 2);
        chk("t6_rfv", 32'(rf_valid), 1);
        chk("t6_noena", 32'(ret_ena), 0);
        tick; #1;
        chk("t6_hold", rf_wdat, 32'hC0);
        chk("t6_occ_hold", 32'(buf_occ), 2);
        #2; rst_n = 0; #1;
        chk("t6_rst_occ", 32'(buf_occ), 0);
        chk("t6_rst_rfv", 32'(rf_valid), 0);
        chk("t6_rst_ena", 32'(ret_ena), 0);
        chk("t6_rst_exv", 32'(excp_valid), 0);
        tick; rst_n = 1; #1;
        chk("t6_lrdy_post", 32'(lsu_ready), 1);
        chk("t6_nrdy_post", 32'(nice_ready), 1);
        chk("t6_occ_post", 32'(buf_occ), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/e203_exu_longp_wbck_sched.md
E203_EXU_LONGP_WBCK_SCHED -- requirements
Module: e203_exu_longp_wbck_sched

Interface
REQ-001 Parameters: OITF_DEPTH, default 2, number of OITF entries and result-buffer slots; ITAG_W, default 1, equal to log2(OITF_DEPTH); XLEN, default 32, data width.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 lsu_wbck_i_valid / lsu_wbck_i_ready  in/out  1/1  LSU long-pipe result handshake.
REQ-005 lsu_wbck_i_wdat / lsu_wbck_i_itag / lsu_wbck_i_err  in  XLEN/ITAG_W/1  result data, OITF pointer tag, error flag.
REQ-006 nice_wbck_i_valid / nice_wbck_i_ready  in/out  1/1  coprocessor (NICE) result handshake.
REQ-007 nice_wbck_i_wdat / nice_wbck_i_itag / nice_wbck_i_err  in  XLEN/ITAG_W/1  result data, tag, error flag.
REQ-008 oitf_empty / oitf_ret_ptr  in  1/ITAG_W  OITF status and oldest-entry pointer.
REQ-009 oitf_ret_rdidx / oitf_ret_rdwen / oitf_ret_pc  in  5/1/XLEN  oldest-entry destination register, write-enable and PC.
REQ-010 oitf_ret_ena  out  1  one-cycle pulse retiring the OITF oldest entry.
REQ-011 rf_wbck_o_valid / rf_wbck_o_ready  out/in  1/1  register-file write-port handshake.
REQ-012 rf_wbck_o_wdat / rf_wbck_o_rdidx  out  XLEN/5  write data and destination register.
REQ-013 excp_o_valid / excp_o_ready  out/in  1/1  long-pipe exception handshake to commit unit.
REQ-014 excp_o_pc  out  XLEN  PC of the faulting instruction.
REQ-015 buf_occ  out  ITAG_W+1  number of valid result-buffer slots.

Function
REQ-016 Result buffer SHALL hold OITF_DEPTH slots, indexed by itag, each storing valid, wdat, err.
REQ-017 lsu_wbck_i_ready SHALL equal NOT slot[lsu_wbck_i_itag].valid; nice_wbck_i_ready SHALL equal NOT slot[nice_wbck_i_itag].valid AND NOT (lsu_wbck_i_valid AND lsu_wbck_i_itag == nice_wbck_i_itag).
REQ-018 On an accepted transfer (valid AND ready), slot[itag] SHALL be written and set valid at the next edge; both requesters with different itags SHALL be accepted in the same cycle.
REQ-019 No bypass: the earliest retirement of a result accepted in cycle N SHALL be cycle N+1.
REQ-020 Retire candidate SHALL exist when oitf_empty=0 AND slot[oitf_ret_ptr].valid=1; other slots SHALL NOT retire.
REQ-021 Candidate err=1: excp_o_valid=1, excp_o_pc=oitf_ret_pc, rf_wbck_o_valid=0; retire on excp_o_ready=1.
REQ-022 Candidate err=0, oitf_ret_rdwen=1: rf_wbck_o_valid=1, rf_wbck_o_wdat=slot wdat, rf_wbck_o_rdidx=oitf_ret_rdidx; retire on rf_wbck_o_ready=1.
REQ-023 Candidate err=0, oitf_ret_rdwen=0: retire in the same cycle with no rf or excp valid.
REQ-024 On retire, oitf_ret_ena SHALL pulse 1 that cycle and slot[oitf_ret_ptr].valid SHALL clear at the next edge; at most one retire per cycle.
REQ-025 A slot being retired SHALL NOT accept a new write in the same cycle (ready follows current valid only).
REQ-026 Outputs valid while the downstream ready is low SHALL hold stable data until the handshake completes.
REQ-027 buf_occ SHALL increment per accept and decrement per retire; simultaneous accept and retire SHALL net correctly; it SHALL never exceed OITF_DEPTH.
REQ-028 ret_ptr wrap (OITF_DEPTH-1 -> 0) SHALL require no special handling; indexing is modulo OITF_DEPTH.
REQ-029 With oitf_empty=1, oitf_ret_ena, rf_wbck_o_valid and excp_o_valid SHALL be 0 regardless of buffer contents.

Reset
REQ-030 rst_n low SHALL immediately clear all slot valids, buf_occ=0, oitf_ret_ena=0, rf_wbck_o_valid=0, excp_o_valid=0; wdat/err storage need not reset.
REQ-031 Reset asserted mid-handshake SHALL abandon the pending result without a retire pulse; both ready outputs SHALL be 1 after release.

Verification
REQ-032 LSU itag=0, wdat=0x12345678, err=0; ret_ptr=0, rdwen=1, rdidx=5, rf_ready=1 -> next cycle rf_wbck_o_valid=1, wdat=0x12345678, rdidx=5, oitf_ret_ena=1; buf_occ 1->0.
REQ-033 NICE itag=1 arrives before LSU itag=0, ret_ptr=0 -> no retire until itag 0 arrives; then retire order 0, 1 on consecutive cycles, ret_ptr wrapping 1->0.
REQ-034 LSU and NICE both valid, both itag=1, slot empty -> lsu accepted, nice_wbck_i_ready=0 that cycle; buf_occ=1.
REQ-035 Err=1 candidate, pc=0x80000100, excp_ready=0 for 3 cycles then 1 -> excp_o_valid held 4 cycles, pc stable, single oitf_ret_ena pulse in cycle 4, rf_wbck_o_valid=0 throughout.
REQ-036 Buffer full (buf_occ=2), rf_ready=0, then rst_n pulsed low -> buf_occ=0, all valids 0 asynchronously, no oitf_ret_ena.
REQ-037 rdwen=0 candidate with rf_ready=0 -> retire same cycle, oitf_ret_ena=1, rf_wbck_o_valid=0.
